// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR random-word scheduler.
// State encodings and the LFSR word width.
package lfsr_pkg;

  localparam int LFSR_W = 32;

  typedef enum logic [1:0] {
    ST_WARMUP = 2'd0,
    ST_FILL   = 2'd1,
    ST_AVAIL  = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Search starts at ptr and wraps; first asserted request wins.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt_next,
  output logic [PTR_W-1:0]   winner
);

  logic             found;
  logic [PTR_W-1:0] idx;
  int               pos;

  always_comb begin
    gnt_next = '0;
    winner   = '0;
    found    = 1'b0;
    idx      = '0;
    pos      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pos = (int'(ptr) + i) % NUM_REQ;
      idx = PTR_W'(pos);
      if (!found && req[idx]) begin
        found         = 1'b1;
        gnt_next[idx] = 1'b1;
        winner        = idx;
      end
    end
  end

endmodule

// File: rtl/lfsr_rand_sched.sv
// Shares one 32-bit LFSR among NUM_REQ requesters.
// Warms the LFSR, then hands out one word per STEPS shifts, round-robin.
module lfsr_rand_sched
  import lfsr_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int STEPS   = 32,
  parameter int WARMUP  = 64,
  parameter int GCNT_W  = 16
) (
  input  logic               clock,
  input  logic               reset,
  output logic               lfsr_enable,
  input  logic [LFSR_W-1:0]  lfsr_seq,
  input  logic               pause,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               rand_valid,
  output logic [LFSR_W-1:0]  rand_data,
  output logic               ready,
  output logic [GCNT_W-1:0]  grant_count
);

  localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_MAX = (WARMUP > STEPS) ? WARMUP : STEPS;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(WARMUP - 1);
  localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(STEPS - 1);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(NUM_REQ - 1);

  state_t               state;
  state_t               state_next;
  logic [CNT_W-1:0]     cnt;
  logic [PTR_W-1:0]     ptr;
  logic [PTR_W-1:0]     winner;
  logic [NUM_REQ-1:0]   gnt_next;
  logic                 phase_done;
  logic                 take;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arb (
    .req      (req),
    .ptr      (ptr),
    .gnt_next (gnt_next),
    .winner   (winner)
  );

  assign phase_done =
    (state == ST_WARMUP && cnt == WARM_LAST) ||
    (state == ST_FILL   && cnt == FILL_LAST);

  assign take = (state == ST_AVAIL) && (|req) && !pause;

  always_ff @(posedge clock) begin
    if (reset) state <= ST_WARMUP;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_WARMUP, ST_FILL:
        if (lfsr_enable && phase_done) state_next = ST_AVAIL;
      ST_AVAIL:
        if (take) state_next = ST_FILL;
      default:
        state_next = ST_WARMUP;
    endcase
  end

  // lfsr_seq is frozen while a word waits in AVAIL
  always_comb begin
    lfsr_enable = (state == ST_WARMUP || state == ST_FILL) && !pause;
    ready       = (state == ST_AVAIL);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
    end else if (lfsr_enable) begin
      cnt <= phase_done ? '0 : cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      gnt         <= '0;
      rand_valid  <= 1'b0;
      rand_data   <= '0;
      grant_count <= '0;
      ptr         <= '0;
    end else begin
      gnt        <= take ? gnt_next : '0;
      rand_valid <= take;
      if (take) begin
        rand_data   <= lfsr_seq;
        grant_count <= grant_count + GCNT_W'(1);
        ptr         <= (winner == PTR_LAST) ? '0 : winner + PTR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_lfsr_rand_sched.sv
// Directed bench for lfsr_rand_sched with a 32-bit LFSR on the same clock.
// Expected grants, counts and words are worked out by the bench.
module tb_lfsr_rand_sched;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        pause = 1'b0;
  logic [3:0]  req   = '0;
  logic        lfsr_enable;
  logic [31:0] lfsr_seq;
  logic [3:0]  gnt;
  logic        rand_valid;
  logic [31:0] rand_data;
  logic        ready;
  logic [3:0]  grant_count;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  always_ff @(posedge clock) begin
    if (reset)
      lfsr_seq <= 32'hACE1_2468;
    else if (lfsr_enable)
      lfsr_seq <= {lfsr_seq[30:0],
        lfsr_seq[31] ^ lfsr_seq[21] ^ lfsr_seq[1] ^ lfsr_seq[0]};
  end

  lfsr_rand_sched #(
    .NUM_REQ (4),
    .STEPS   (32),
    .WARMUP  (64),
    .GCNT_W  (4)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .lfsr_enable (lfsr_enable),
    .lfsr_seq    (lfsr_seq),
    .pause       (pause),
    .req         (req),
    .gnt         (gnt),
    .rand_valid  (rand_valid),
    .rand_data   (rand_data),
    .ready       (ready),
    .grant_count (grant_count)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Runs a WARMUP/FILL phase from the current negedge until ready,
  // holding pause high for cycles [ps, ps+pl).
  task automatic run_phase(input int ps, input int pl,
                           output int en, output int cyc,
                           output int enp);
    en  = 0;
    cyc = 0;
    enp = 0;
    while (!ready && cyc < 500) begin
      pause = (cyc >= ps) && (cyc < ps + pl);
      #1;
      if (lfsr_enable) begin
        en++;
        if (pause) enp++;
      end
      @(negedge clock);
      cyc++;
    end
    pause = 1'b0;
    if (!ready) check("phase_timeout", 32'(ready), 32'd1);
  endtask

  task automatic warm_restart();
    int en, cyc, enp;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    run_phase(0, 0, en, cyc, enp);
    check("rewarm_en", en, 64);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int en, cyc, enp;
    int t, last_t, uniq;
    logic [31:0] d;
    logic [31:0] words [5];
    logic [3:0]  exp_g [5];
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // 1: reset and warmup
    repeat (5) begin
      @(negedge clock);
      check("rst_gnt", 32'(gnt), 0);
      check("rst_valid", 32'(rand_valid), 0);
      check("rst_data", rand_data, 0);
      check("rst_ready", 32'(ready), 0);
      check("rst_gcnt", 32'(grant_count), 0);
    end
    reset = 1'b0;
    run_phase(0, 0, en, cyc, enp);
    check("warm_en", en, 64);
    check("warm_cyc", cyc, 64);
    check("warm_lfsr_off", 32'(lfsr_enable), 0);

    // 2: single request
    req = 4'b0100;
    d   = lfsr_seq;
    @(negedge clock);
    req = '0;
    check("t2_gnt", 32'(gnt), 32'b0100);
    check("t2_valid", 32'(rand_valid), 1);
    check("t2_data", rand_data, d);
    check("t2_gcnt", 32'(grant_count), 1);
    check("t2_ready", 32'(ready), 0);
    run_phase(0, 0, en, cyc, enp);
    check("t2_fill_en", en, 32);
    check("t2_fill_cyc", cyc, 32);
    repeat (3) begin
      @(negedge clock);
      check("t2_idle_gnt", 32'(gnt), 0);
      check("t2_idle_valid", 32'(rand_valid), 0);
      check("t2_hold_data", rand_data, d);
    end

    // 3: all requesting, from a fresh reset
    warm_restart();
    req    = 4'b1111;
    t      = 0;
    last_t = 0;
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 100; i++) begin
        d = lfsr_seq;
        @(negedge clock);
        t++;
        if (rand_valid) break;
      end
      check("t3_gnt", 32'(gnt), 32'(exp_g[k]));
      check("t3_data", rand_data, d);
      if (k > 0) check("t3_gap", t - last_t, 33);
      last_t   = t;
      words[k] = rand_data;
    end
    req  = '0;
    uniq = 1;
    for (int a = 0; a < 5; a++)
      for (int b = a + 1; b < 5; b++)
        if (words[a] == words[b]) uniq = 0;
    check("t3_distinct", uniq, 1);
    check("t3_gcnt", 32'(grant_count), 5);

    // 4: pause for 7 cycles from FILL step 10
    run_phase(10, 7, en, cyc, enp);
    check("t4_en", en, 32);
    check("t4_cyc", cyc, 39);
    check("t4_en_paused", enp, 0);
    pause = 1'b1;
    req   = 4'b0001;
    repeat (3) begin
      @(negedge clock);
      check("t4_pause_gnt", 32'(gnt), 0);
      check("t4_pause_ready", 32'(ready), 1);
    end
    pause = 1'b0;
    d     = lfsr_seq;
    @(negedge clock);
    req = '0;
    check("t4_gnt", 32'(gnt), 32'b0001);
    check("t4_data", rand_data, d);
    check("t4_gcnt", 32'(grant_count), 6);

    // 5a: reset mid-FILL
    repeat (5) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("t5a_gnt", 32'(gnt), 0);
    check("t5a_valid", 32'(rand_valid), 0);
    check("t5a_gcnt", 32'(grant_count), 0);
    check("t5a_ready", 32'(ready), 0);
    run_phase(0, 0, en, cyc, enp);
    check("t5a_warm_en", en, 64);
    req = 4'b1111;
    @(negedge clock);
    req = '0;
    check("t5a_first", 32'(gnt), 32'b0001);
    run_phase(0, 0, en, cyc, enp);

    // 5b: reset on the grant edge
    req   = 4'b1111;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("t5b_gnt", 32'(gnt), 0);
    check("t5b_valid", 32'(rand_valid), 0);
    check("t5b_gcnt", 32'(grant_count), 0);
    run_phase(0, 0, en, cyc, enp);
    check("t5b_warm_en", en, 64);
    @(negedge clock);
    req = '0;
    check("t5b_first", 32'(gnt), 32'b0001);
    run_phase(0, 0, en, cyc, enp);

    // 6: counter wrap
    warm_restart();
    for (int k = 1; k <= 16; k++) begin
      req = 4'b0001;
      @(negedge clock);
      req = '0;
      check("t6_gnt", 32'(gnt), 32'b0001);
      check("t6_gcnt", 32'(grant_count), 32'(k % 16));
      run_phase(0, 0, en, cyc, enp);
      repeat (2) begin
        @(negedge clock);
        check("t6_idle_valid", 32'(rand_valid), 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
